mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single external data-SRAM port between two requesters: the cpu data port
//  (address from alu_bus, write data from reg_r_bus) and the debug/loader port.
//  Sits between the cpu top level and the board SRAM pins.
//  Provides a req/ack handshake, round-robin arbitration and a programmable wait-state sequencer.
// PARAMETERS
//  AW           16  address width, both requesters and SRAM
//  DW           16  data width
//  WAIT_STATES   2  SRAM access cycles after address setup; legal range 1..15
// PORTS
//  clk        in   1   single clock, all state on rising edge
//  rst        in   1   asynchronous, active-low reset (rst==0 resets)
//  cpu_req    in   1   cpu access request, held until cpu_ack
//  cpu_we     in   1   1=write, 0=read; stable while cpu_req
//  cpu_addr   in   AW  access address; stable while cpu_req
//  cpu_wdata  in   DW  write data; stable while cpu_req
//  cpu_ack    out  1   one-cycle completion pulse
//  cpu_rdata  out  DW  read data, valid in cpu_ack cycle, held until next cpu ack
//  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata: same as cpu_*, debug requester
//  mem_addr   out  AW  SRAM address
//  mem_wdata  out  DW  SRAM write data
//  mem_we     out  1   SRAM write enable, active high
//  mem_oe     out  1   SRAM output enable, active high
//  mem_rdata  in   DW  SRAM read data
//  busy       out  1   1 while state != IDLE
//  gnt_id     out  1   owner of current/last access: 0=cpu, 1=dbg
// BEHAVIOUR
//  - Reset: state=IDLE, wait counter=0, last_gnt=1 (dbg), so cpu wins the first tie.
//    All outputs 0: acks, rdata, mem_*, busy, gnt_id.
//    Reset mid-access aborts immediately; no ack is issued for the aborted access.
//  - FSM IDLE -> ACCESS -> DONE -> IDLE. All outputs registered.
//  - IDLE: sample the req lines.
//    - Only one req high: grant that requester.
//    - Both high: grant the requester != last_gnt.
//    - On grant: latch we/addr/wdata into internal regs, set gnt_id and last_gnt,
//      load counter=WAIT_STATES, go to ACCESS.
//  - ACCESS lasts WAIT_STATES+1 cycles.
//    - mem_addr/mem_wdata driven from the latch for every cycle.
//    - First cycle is address setup: mem_we=0; mem_oe=1 for reads only.
//    - Remaining WAIT_STATES cycles: mem_we=1 for writes; mem_oe=1 for reads.
//    - Counter decrements once per cycle after setup. When it reaches 0, mem_rdata is
//      captured into the granted requester's rdata register (reads only) and state goes to DONE.
//  - DONE, one cycle:
//    - granted ack=1; mem_we=mem_oe=0; mem_addr holds its value; req lines ignored.
//    - Then go to IDLE.
//  - Latency: req first high in IDLE cycle T -> ack in cycle T+WAIT_STATES+2.
//    Next grant is possible at T+WAIT_STATES+3.
//  - Requester must drop req in the cycle after ack. A req still high in the following
//    IDLE cycle is a new access. A req dropped before ack does not cancel the granted access.
//  - The losing requester keeps waiting. Round-robin guarantees it the next grant,
//    so worst-case wait is 2*(WAIT_STATES+3) cycles.
//  - rdata of the requester that was not granted is never modified. Writes leave rdata unchanged.
//  - WAIT_STATES outside 1..15: elaboration error.
// STRUCTURE
//  - Shared package mem_arb_pkg:
//    - state encoding ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_DONE=2'd2
//    - requester ids REQ_CPU=1'b0, REQ_DBG=1'b1
//    - counter width WS_W=4
//  - One sub-module: rr_arb2. Combinational 2-way round-robin picker:
//    inputs req[1:0] and last_gnt; outputs gnt_valid and gnt_id.
//  - FSM, counter and latches live in mem_arbiter.
// TESTING
//  - Reset with WAIT_STATES=2: all outputs 0, busy=0. rst low mid-ACCESS -> next cycle all 0,
//    no ack ever issued.
//  - cpu read 0x0040 with SRAM model returning 0xBEEF:
//    mem_oe=1 for 3 cycles, cpu_ack 4 cycles after cpu_req, cpu_rdata=0xBEEF.
//  - cpu write 0x1234 to 0x00A0: mem_addr=0x00A0 for 3 cycles; mem_we=0 in cycle 1,
//    1 in cycles 2-3; SRAM model reads back 0x1234.
//  - cpu_req and dbg_req both held high from reset for 4 accesses:
//    grant order cpu,dbg,cpu,dbg; gnt_id toggles; no back-to-back grants to the same requester.
//  - dbg read 0x0010 (SRAM returns 0x5A5A) while cpu idle:
//    dbg_rdata=0x5A5A, cpu_rdata keeps its prior value, cpu_ack never pulses.
//  - WAIT_STATES=1 and WAIT_STATES=15 builds: req->ack latency is exactly 3 and 17 cycles.
//    req kept high after ack starts a second access with no gap beyond the DONE cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the SRAM port arbiter: FSM encoding, requester ids
// and the wait-state counter width.
package mem_arb_pkg;

   localparam int unsigned WS_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. req[0] is the cpu, req[1] the debug port.
// On a tie the requester that did not win last time is chosen.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_gnt,
   output logic       gnt_valid,
   output logic       gnt_id
);

   // pick a winner from the current request pair
   always_comb begin
      gnt_valid = |req;
      gnt_id    = REQ_CPU;
      if (req == 2'b11)
         gnt_id = ~last_gnt;
      else if (req[1])
         gnt_id = REQ_DBG;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one external data-SRAM port between the cpu data port and the
// debug/loader port: req/ack handshake, round-robin arbitration and a
// programmable wait-state sequencer. All outputs are registered.
module mem_arbiter #(
   parameter int unsigned AW          = 16,
   parameter int unsigned DW          = 16,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic          dbg_ack,
   output logic [DW-1:0] dbg_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   output logic          mem_oe,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic          gnt_id
);

   import mem_arb_pkg::*;

   if ((WAIT_STATES < 1) || (WAIT_STATES > 15)) begin : g_bad_ws
      $error("mem_arbiter: WAIT_STATES must be in 1..15");
   end

   localparam logic [WS_W-1:0] WS_LOAD = WS_W'(WAIT_STATES);

   state_t          state;
   logic [WS_W-1:0] cnt;
   logic            setup;
   logic            last_gnt;
   logic            lat_we;

   logic            pick_valid;
   logic            pick_id;
   logic            sel_we;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_wdata;

   rr_arb2 u_rr (
      .req       ({dbg_req, cpu_req}),
      .last_gnt  (last_gnt),
      .gnt_valid (pick_valid),
      .gnt_id    (pick_id)
   );

   // route the winning requester's access fields to the latch inputs
   always_comb begin
      sel_we    = cpu_we;
      sel_addr  = cpu_addr;
      sel_wdata = cpu_wdata;
      if (pick_id == REQ_DBG) begin
         sel_we    = dbg_we;
         sel_addr  = dbg_addr;
         sel_wdata = dbg_wdata;
      end
   end

   // access sequencer: grant, address setup, wait states, ack
   // mem_addr/mem_wdata double as the access latch, so they hold after DONE
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         setup     <= 1'b0;
         last_gnt  <= REQ_DBG;
         lat_we    <= 1'b0;
         gnt_id    <= 1'b0;
         busy      <= 1'b0;
         cpu_ack   <= 1'b0;
         dbg_ack   <= 1'b0;
         cpu_rdata <= '0;
         dbg_rdata <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
         mem_oe    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  state     <= ST_ACCESS;
                  gnt_id    <= pick_id;
                  last_gnt  <= pick_id;
                  lat_we    <= sel_we;
                  mem_addr  <= sel_addr;
                  mem_wdata <= sel_wdata;
                  mem_we    <= 1'b0;
                  mem_oe    <= ~sel_we;
                  busy      <= 1'b1;
                  cnt       <= WS_LOAD;
                  setup     <= 1'b1;
               end
            end
            ST_ACCESS: begin
               if (setup) begin
                  setup  <= 1'b0;
                  mem_we <= lat_we;
                  mem_oe <= ~lat_we;
               end else if (cnt == WS_W'(1)) begin
                  cnt    <= '0;
                  mem_we <= 1'b0;
                  mem_oe <= 1'b0;
                  state  <= ST_DONE;
                  if (gnt_id == REQ_CPU) begin
                     cpu_ack <= 1'b1;
                     if (!lat_we) cpu_rdata <= mem_rdata;
                  end else begin
                     dbg_ack <= 1'b1;
                     if (!lat_we) dbg_rdata <= mem_rdata;
                  end
               end else begin
                  cnt <= cnt - WS_W'(1);
               end
            end
            ST_DONE: begin
               cpu_ack <= 1'b0;
               dbg_ack <= 1'b0;
               busy    <= 1'b0;
               state   <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
